// File: rtl/sobol_stream_sched_pkg.sv
// Shared definitions for the Sobol stream scheduler: FSM state encoding and width helpers.
package sobol_stream_sched_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Index width for a pointer over n requesters (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobol_stream_sched_rr_arbiter.sv
// Combinational round-robin arbiter: scans requests starting at iPtr and returns the first
// active requester as a one-hot winner (all zero when nothing is requested).
module rr_arbiter
  import sobol_stream_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PtrW = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] iReq,
  input  logic [PtrW-1:0] iPtr,
  output logic [NREQ-1:0] oWin
);

  logic [PtrW-1:0] w_idx;
  logic            w_found;

  // Walk the requesters in priority order beginning at the pointer.
  always_comb begin
    oWin    = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = PtrW'((32'(iPtr) + i) % NREQ);
      if (!w_found && iReq[w_idx]) begin
        oWin[w_idx] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobol_stream_sched.sv
// Shares one Sobol RNG among NREQ requesters. Each grant clears the RNG, then streams
// 2^BITWIDTH unary bits (operand > rand) and pulses done on the granted line.
// Optional feature: define SCHED_BACKPRESSURE_EN to stall the stream while iReady is low.
module sobol_stream_sched
  import sobol_stream_sched_pkg::*;
#(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned NREQ     = 4
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [NREQ-1:0]          iReq,
  input  logic [NREQ*BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0]      iRand,
  output logic                     oRngEn,
  output logic                     oRngClr,
  output logic [NREQ-1:0]          oGnt,
  output logic                     oBit,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [NREQ-1:0]          oDone,
  output logic                     oBusy
);

  localparam int unsigned PtrW = ptr_width(NREQ);

  state_e              r_state, w_state_d;
  logic [NREQ-1:0]     r_gnt, w_gnt_d;
  logic [BITWIDTH-1:0] r_op, w_op_d;
  logic [BITWIDTH-1:0] r_cnt, w_cnt_d;
  logic [PtrW-1:0]     r_ptr, w_ptr_d;

  logic [NREQ-1:0]     w_win;
  logic [BITWIDTH-1:0] w_win_op;
  logic [PtrW-1:0]     w_gnt_idx;
  logic [PtrW-1:0]     w_ptr_next;
  logic                w_req_held;
  logic                w_consume;

  rr_arbiter #(
    .NREQ (NREQ),
    .PtrW (PtrW)
  ) u_arb (
    .iReq (iReq),
    .iPtr (r_ptr),
    .oWin (w_win)
  );

`ifdef SCHED_BACKPRESSURE_EN
  assign w_consume = iReady;
`else
  logic w_unused_ready;
  assign w_unused_ready = iReady;
  assign w_consume      = 1'b1;
`endif

  assign oGnt       = r_gnt;
  assign oBusy      = (r_state != StIdle);
  assign w_req_held = |(iReq & r_gnt);
  assign w_ptr_next = (w_gnt_idx == PtrW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Operand of the arbitration winner and index of the current grant.
  always_comb begin
    w_win_op  = '0;
    w_gnt_idx = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (w_win[k]) w_win_op = iData[k*BITWIDTH +: BITWIDTH];
      if (r_gnt[k]) w_gnt_idx = PtrW'(k);
    end
  end

  // Next-state and output decode; an aborted stream behaves like a silent DONE.
  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_op_d    = r_op;
    w_cnt_d   = r_cnt;
    w_ptr_d   = r_ptr;
    oRngEn    = 1'b0;
    oRngClr   = 1'b0;
    oValid    = 1'b0;
    oBit      = 1'b0;
    oDone     = '0;
    unique case (r_state)
      StIdle: begin
        if (|iReq) begin
          w_gnt_d   = w_win;
          w_op_d    = w_win_op;
          w_state_d = StClear;
        end
      end
      StClear: begin
        oRngClr = 1'b1;
        w_cnt_d = '0;
        if (!w_req_held) begin
          w_state_d = StIdle;
          w_gnt_d   = '0;
          w_ptr_d   = w_ptr_next;
        end else begin
          w_state_d = StRun;
        end
      end
      StRun: begin
        oValid = 1'b1;
        oBit   = (r_op > iRand);
        oRngEn = w_consume;
        if (!w_req_held) begin
          w_state_d = StIdle;
          w_gnt_d   = '0;
          w_ptr_d   = w_ptr_next;
        end else if (w_consume) begin
          if (&r_cnt) w_state_d = StDone;
          else        w_cnt_d   = r_cnt + 1'b1;
        end
      end
      StDone: begin
        oDone     = r_gnt;
        w_gnt_d   = '0;
        w_ptr_d   = w_ptr_next;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State, grant, operand, counter and round-robin pointer registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_op    <= w_op_d;
      r_cnt   <= w_cnt_d;
      r_ptr   <= w_ptr_d;
    end
  end

endmodule

// File: tb/tb_sobol_stream_sched.sv
// Directed bench for sobol_stream_sched with a behavioural first-dimension Sobol RNG in loop.
module tb_sobol_stream_sched;

  localparam int unsigned BW = 8;
  localparam int unsigned NR = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*BW-1:0] data = '0;
  logic [BW-1:0]    rnd;
  logic             rdy = 1'b1;
  logic             rng_en, rng_clr, bit_o, vld, busy;
  logic [NR-1:0]    gnt, done;
  logic             rdy_eff;

  int unsigned n_assert = 0, n_fail = 0;
  int unsigned acc = 0, ones = 0, done_cnt = 0, rng_bad = 0;
  int unsigned acc0 = 0, ones0 = 0, done0 = 0;
  int          gap;

  logic [BW-1:0] s_val = '0;
  logic [BW-1:0] s_cnt = '0;

  sobol_stream_sched #(
    .BITWIDTH (BW),
    .NREQ     (NR)
  ) dut (
    .iClk    (clk),
    .iRst    (rst),
    .iReq    (req),
    .iData   (data),
    .iRand   (rnd),
    .oRngEn  (rng_en),
    .oRngClr (rng_clr),
    .oGnt    (gnt),
    .oBit    (bit_o),
    .oValid  (vld),
    .iReady  (rdy),
    .oDone   (done),
    .oBusy   (busy)
  );

  always #5 clk = ~clk;

`ifdef SCHED_BACKPRESSURE_EN
  assign rdy_eff = rdy;
`else
  assign rdy_eff = 1'b1;
`endif

  // Direction number for the lowest zero bit of the step index (gray-code Sobol, dim 1).
  function automatic logic [BW-1:0] sobol_dir(input logic [BW-1:0] c);
    logic [BW-1:0] v;
    logic [BW-1:0] top;
    v   = '0;
    top = {1'b1, {(BW-1){1'b0}}};
    for (int b = BW - 1; b >= 0; b--) if (!c[b]) v = top >> b;
    return v;
  endfunction

  assign rnd = s_val;

  always @(posedge clk) begin
    if (rng_clr) begin
      s_val <= '0;
      s_cnt <= '0;
    end else if (rng_en) begin
      s_val <= s_val ^ sobol_dir(s_cnt);
      s_cnt <= s_cnt + 1'b1;
    end
  end

  // Random ready in both builds; the default build must ignore it.
  always @(posedge clk) rdy <= 1'($urandom_range(0, 1));

  // Beat, ones and done counters plus an RNG-enable consistency monitor.
  always @(negedge clk) begin
    if (vld && rdy_eff) begin
      acc <= acc + 1;
      if (bit_o) ones <= ones + 1;
    end
    if (done != '0) done_cnt <= done_cnt + 1;
    if (rng_en != (vld && rdy_eff)) rng_bad <= rng_bad + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clear(input logic [NR-1:0] exp_gnt, input string tag, output int g);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!rng_clr && g < 20);
    check_eq({tag, "_clr_seen"}, 32'(rng_clr), 1);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    check_eq({tag, "_en_in_clr"}, 32'(rng_en), 0);
    acc0  = acc;
    ones0 = ones;
    done0 = done_cnt;
  endtask

  task automatic wait_done(input logic [NR-1:0] exp_done, input int unsigned exp_ones,
                           input string tag);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 3000);
    check_eq({tag, "_timeout"}, 32'(done == '0), 0);
    check_eq({tag, "_done"}, 32'(done), 32'(exp_done));
    check_eq({tag, "_beats"}, acc - acc0, 256);
    check_eq({tag, "_ones"}, ones - ones0, exp_ones);
  endtask

  task automatic post_done(input string tag);
    @(negedge clk);
    check_eq({tag, "_idle_busy"}, 32'(busy), 0);
    check_eq({tag, "_idle_gnt"}, 32'(gnt), 0);
    check_eq({tag, "_done_once"}, done_cnt - done0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", 32'({rng_en, rng_clr, gnt, bit_o, vld, done, busy}), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 0);

    // Single request; operand changes after grant must be ignored.
    data[7:0] = 8'h40;
    req       = 4'b0001;
    wait_clear(4'b0001, "t1", gap);
    data[7:0] = 8'hFF;
    wait_done(4'b0001, 64, "t1");
    req = '0;
    post_done("t1");

    // Extreme operands.
    data[15:8] = 8'h00;
    req        = 4'b0010;
    wait_clear(4'b0010, "t2_zero", gap);
    wait_done(4'b0010, 0, "t2_zero");
    req = '0;
    post_done("t2_zero");
    data[23:16] = 8'hFF;
    req         = 4'b0100;
    wait_clear(4'b0100, "t2_full", gap);
    wait_done(4'b0100, 255, "t2_full");
    req = '0;
    post_done("t2_full");

    // Reset restores requester 0 as highest priority.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 rst = 1'b0;

    // Round-robin with all requests held.
    data = 32'h40302010;
    req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int k;
      k = i % 4;
      wait_clear(NR'(1 << k), $sformatf("t3_g%0d", i), gap);
      if (i > 0) check_eq($sformatf("t3_gap%0d", i), 32'(gap), 1);
      wait_done(NR'(1 << k), 16 * (k + 1), $sformatf("t3_g%0d", i));
      if (i == 4) req = '0;
      post_done($sformatf("t3_g%0d", i));
    end

    // Abort requester 2 at RUN cycle 100; requester 3 is next.
    data[31:24] = 8'h21;
    req         = 4'b1100;
    wait_clear(4'b0100, "t4_a", gap);
    repeat (100) @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    check_eq("t4_abort_valid", 32'(vld), 0);
    check_eq("t4_abort_busy", 32'(busy), 0);
    check_eq("t4_abort_gnt", 32'(gnt), 0);
    check_eq("t4_abort_nodone", done_cnt - done0, 0);
    wait_clear(4'b1000, "t4_b", gap);
    check_eq("t4_gap", 32'(gap), 1);
    wait_done(4'b1000, 33, "t4_b");
    req = '0;
    post_done("t4_b");

    // Asynchronous reset mid-RUN, then a full stream.
    data[7:0] = 8'h80;
    req       = 4'b0001;
    wait_clear(4'b0001, "t5_a", gap);
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_eq("t5_rst_outputs", 32'({rng_en, rng_clr, gnt, bit_o, vld, done, busy}), 0);
    #1 rst = 1'b0;
    wait_clear(4'b0001, "t5_b", gap);
    wait_done(4'b0001, 128, "t5_b");
    req = '0;
    post_done("t5_b");

    check_eq("rng_en_consistency", rng_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
